lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit controller sitting directly downstream of the execute stage. It takes the effective address computed by the ALU (`ALU_Result`) and the store operand (`Rs2`) and runs one data-memory transaction per instruction over a request/grant/response bus. It generates byte enables and lane-replicated store data, and extracts and sign- or zero-extends load data for register writeback. It also flags misaligned or illegal accesses, and bus timeouts.

## Interface
Parameters:
- `TIMEOUT` — default 255 — max cycles spent in WAIT before a bus error; legal range 1..255.

Ports:
- `clk` — in, 1 — single clock; all state updates on the rising edge.
- `rst` — in, 1 — reset; synchronous, active-high.
- `req_valid` — in, 1 — memory instruction presented by execute.
- `req_ready` — out, 1 — unit can accept; high only in IDLE.
- `is_load` — in, 1 — request is a load.
- `is_store` — in, 1 — request is a store.
- `funct3` — in, 3 — 000 B, 001 H, 010 W, 100 BU, 101 HU; stores accept only 000/001/010.
- `addr` — in, 32 — effective byte address (ALU result).
- `wdata` — in, 32 — store operand (Rs2).
- `rd` — in, 5 — load destination register.
- `mem_req` — out, 1 — bus request.
- `mem_we` — out, 1 — 1 = write.
- `mem_addr` — out, 32 — word-aligned address, `{addr[31:2],2'b00}`.
- `mem_be` — out, 4 — byte enables; bit i enables byte lane i.
- `mem_wdata` — out, 32 — lane-replicated store data.
- `mem_gnt` — in, 1 — bus accepted the request.
- `mem_rvalid` — in, 1 — response beat; acknowledges loads and stores.
- `mem_rdata` — in, 32 — read data; valid with `mem_rvalid`.
- `wb_valid` — out, 1 — one-cycle pulse; writeback data valid.
- `wb_rd` — out, 5 — writeback register.
- `wb_data` — out, 32 — extended load data.
- `done` — out, 1 — one-cycle pulse; instruction retired (load or store).
- `err` — out, 1 — one-cycle pulse; misaligned, illegal, or timeout.
- `err_code` — out, 2 — 01 misaligned, 10 illegal op, 11 bus timeout; valid with `err`.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- Accept: `req_valid && req_ready`. On accept, latch op, `funct3`, `addr[1:0]`, `rd`, `mem_addr`, `mem_be`, `mem_wdata`.
- Illegal op: `is_load==is_store`, or `funct3` not legal for the op.
  - Check runs at accept time. Illegal has priority over misaligned.
  - No bus request is issued; `err` pulses the next cycle; state stays IDLE.
- Misaligned: H/HU/SH with `addr[0]==1`, or W/SW with `addr[1:0]!=0`.
  - Next cycle: `err`, `err_code=01`; no bus request; state stays IDLE.
- Legal access: IDLE→REQ. `mem_req` is high throughout REQ.
  - REQ→WAIT on `mem_gnt`. `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` are held stable until the grant.
- WAIT:
  - On `mem_rvalid`, a load captures the extended data and goes to RESP.
  - On `mem_rvalid`, a store pulses `done` the next cycle and returns to IDLE.
  - `mem_rvalid` outside WAIT is ignored.
- RESP: `wb_valid=1` and `done=1` for exactly one cycle, then IDLE.
- Byte enables / store data (`off = addr[1:0]`):
  - B: `be = 4'b0001<<off`, `wdata[7:0]` replicated ×4.
  - H: `be = off[1] ? 1100 : 0011`, `wdata[15:0]` replicated ×2.
  - W: `be = 1111`, `wdata` unchanged.
  - Loads drive the same `be` pattern with `mem_we=0`.
- Load extract:
  - `lane = mem_rdata >> (8*off)`.
  - B/H: sign-extend bit 7 / bit 15.
  - BU/HU: zero-extend.
  - W: unchanged.
- Timeout: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle without `mem_rvalid`.
  - When the count reaches `TIMEOUT`: `err`, `err_code=11`, return to IDLE, no writeback.
  - A later `mem_rvalid` is ignored.

## Timing
- Reset: state=IDLE, counter=0.
  - `req_ready=1` from the first cycle after reset deasserts.
  - `mem_req=0`, `mem_we=0`, `mem_be=0`, `mem_addr=0`, `mem_wdata=0`, `wb_valid=0`, `wb_rd=0`, `wb_data=0`, `done=0`, `err=0`, `err_code=0`.
- Reset mid-transaction aborts it. No `wb_valid`, `done`, or `err` follows.
- Accept at cycle 0 → `mem_req` high from cycle 1.
- Best-case load: `gnt` in cycle 1, `rvalid` in cycle 2, `wb_valid` in cycle 3.
- Best-case store: `done` in cycle 3.
- Each extra grant or response wait cycle adds exactly one cycle of latency.
- Error pulse appears at cycle 1; `req_ready` stays high, so back-to-back requests are accepted.
- Throughput: one outstanding transaction. `req_ready=0` in REQ, WAIT, RESP.
- `rvalid` arriving the cycle after `gnt` is legal. `rvalid` in the same cycle as `gnt` is ignored; the bus never does this.

## Test plan
- LW `addr=0x100`, `rd=5`; `gnt` cycle 1; `rvalid` cycle 2, `rdata=0xDEADBEEF` → `mem_addr=0x100`, `be=1111`; `wb_valid` cycle 3 with `wb_rd=5`, `wb_data=0xDEADBEEF`.
- LB `addr=0x103`, `rdata=0x80FF_1234` → `be=1000`, `wb_data=0xFFFFFF80`. LBU at the same address → `0x00000080`.
- SH `addr=0x202`, `wdata=0x0000ABCD` → `mem_we=1`, `mem_addr=0x200`, `be=1100`, `mem_wdata=0xABCDABCD`; `done` one cycle after `rvalid`; no `wb_valid`.
- LW `addr=0x101` → no `mem_req`; `err=1`, `err_code=01` at cycle 1. Store with `funct3=100` → `err_code=10`. Both flags set → `err_code=10`.
- `TIMEOUT=4`; grant LW, never assert `rvalid` → `err=1`, `err_code=11` on the 4th WAIT cycle, then `req_ready=1`. A late `rvalid` produces no `wb_valid`.
- `gnt` withheld for 3 cycles → `mem_*` outputs stable throughout. Assert `rst` in WAIT → all outputs at reset values next cycle; no `wb_valid`.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one data-memory transaction per instruction over a
// request/grant/response bus, with byte lanes, load extension, and error reporting.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_t      state;
    logic        op_load;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;

    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] lane;
    logic [31:0] load_ext;

    assign req_ready = (state == IDLE);
    assign cnt_inc   = cnt + 8'd1;

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        be_n       = 4'b1111;
        wdata_n    = wdata;

        if (is_load == is_store)
            illegal = 1'b1;
        else if (is_load)
            illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else
            illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});

        // funct3[1:0] encodes access size for both signed and unsigned loads
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

        case (funct3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << addr[1:0];
                wdata_n = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_n    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{wdata[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = wdata;
            end
        endcase
    end

    always_comb begin
        lane = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'd0, lane[7:0]};
            3'b101:  load_ext = {16'd0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_load   <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
            rd_q      <= '0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
        end else begin
            wb_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_load <= is_load;
                        f3_q    <= funct3;
                        off_q   <= addr[1:0];
                        rd_q    <= rd;
                        if (illegal) begin
                            err      <= 1'b1;
                            err_code <= 2'b10;
                        end else if (misaligned) begin
                            err      <= 1'b1;
                            err_code <= 2'b01;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be_n;
                            mem_wdata <= wdata_n;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        cnt     <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (op_load) begin
                            wb_data  <= load_ext;
                            wb_rd    <= rd_q;
                            wb_valid <= 1'b1;
                            done     <= 1'b1;
                            state    <= RESP;
                        end else begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else if (cnt_inc == TO_LIMIT) begin
                        err      <= 1'b1;
                        err_code <= 2'b11;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl; DUT built with a short bus timeout.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int fails  = 0;

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rd(rd), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .done(done),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr();
        req_valid  = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        addr       = '0;
        wdata      = '0;
        rd         = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
        req_valid = 1'b1;
        is_load   = ld;
        is_store  = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        rd        = r;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr();
        step();
        step();
        checks++; if ({mem_req, mem_we, mem_be, wb_valid, done, err, err_code} !== 11'd0) begin fails++; $display("FAIL reset_ctl: got %b want 0", {mem_req, mem_we, mem_be, wb_valid, done, err, err_code}); end
        checks++; if ({mem_addr, mem_wdata, wb_data, wb_rd} !== 101'd0) begin fails++; $display("FAIL reset_data: got %h %h %h %h want 0", mem_addr, mem_wdata, wb_data, wb_rd); end
        rst = 1'b0;
        step();
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    // Best-case load: grant in cycle 1, response in cycle 2, writeback in cycle 3.
    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [4:0] r, input logic [31:0] rdat,
                             input logic [3:0] exp_be, input logic [31:0] exp_data);
        issue(1'b1, 1'b0, f3, a, 32'h0, r);
        step();
        checks++; if ({mem_req, mem_we, req_ready} !== 3'b100) begin fails++; $display("FAIL %s_req: got req/we/rdy %b want 100", name, {mem_req, mem_we, req_ready}); end
        checks++; if (mem_addr !== {a[31:2], 2'b00}) begin fails++; $display("FAIL %s_addr: got %h want %h", name, mem_addr, {a[31:2], 2'b00}); end
        checks++; if (mem_be !== exp_be) begin fails++; $display("FAIL %s_be: got %b want %b", name, mem_be, exp_be); end
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        step();
        checks++; if ({mem_req, wb_valid} !== 2'b00) begin fails++; $display("FAIL %s_wait: got req/wb %b want 00", name, {mem_req, wb_valid}); end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdat;
        step();
        mem_rvalid = 1'b0;
        checks++; if ({wb_valid, done} !== 2'b11) begin fails++; $display("FAIL %s_wbv: got wb/done %b want 11", name, {wb_valid, done}); end
        checks++; if (wb_data !== exp_data) begin fails++; $display("FAIL %s_data: got %h want %h", name, wb_data, exp_data); end
        checks++; if (wb_rd !== r) begin fails++; $display("FAIL %s_rd: got %0d want %0d", name, wb_rd, r); end
        step();
        checks++; if ({wb_valid, done, req_ready} !== 3'b001) begin fails++; $display("FAIL %s_end: got wb/done/rdy %b want 001", name, {wb_valid, done, req_ready}); end
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        issue(1'b0, 1'b1, f3, a, wd, 5'd0);
        step();
        checks++; if ({mem_req, mem_we} !== 2'b11) begin fails++; $display("FAIL %s_req: got req/we %b want 11", name, {mem_req, mem_we}); end
        checks++; if (mem_addr !== exp_addr) begin fails++; $display("FAIL %s_addr: got %h want %h", name, mem_addr, exp_addr); end
        checks++; if (mem_be !== exp_be) begin fails++; $display("FAIL %s_be: got %b want %b", name, mem_be, exp_be); end
        checks++; if (mem_wdata !== exp_wdata) begin fails++; $display("FAIL %s_wdata: got %h want %h", name, mem_wdata, exp_wdata); end
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        checks++; if ({done, wb_valid, req_ready} !== 3'b101) begin fails++; $display("FAIL %s_done: got done/wb/rdy %b want 101", name, {done, wb_valid, req_ready}); end
        step();
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL %s_done_pulse: got %b want 0", name, done); end
    endtask

    task automatic test_errors();
        // Misaligned LW followed back-to-back by an illegal store, then both flags at once.
        issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd1);
        step();
        checks++; if ({err, err_code, mem_req, req_ready} !== 5'b10101) begin fails++; $display("FAIL err_misalign: got err/code/req/rdy %b want 10101", {err, err_code, mem_req, req_ready}); end
        issue(1'b0, 1'b1, 3'b100, 32'h200, 32'h0, 5'd0);
        step();
        checks++; if ({err, err_code, mem_req} !== 4'b1100) begin fails++; $display("FAIL err_illegal: got err/code/req %b want 1100", {err, err_code, mem_req}); end
        issue(1'b1, 1'b1, 3'b010, 32'h103, 32'h0, 5'd0);
        step();
        checks++; if ({err, err_code, mem_req} !== 4'b1100) begin fails++; $display("FAIL err_both: got err/code/req %b want 1100", {err, err_code, mem_req}); end
        issue(1'b1, 1'b0, 3'b101, 32'h105, 32'h0, 5'd0);
        step();
        checks++; if ({err, err_code, mem_req} !== 4'b1010) begin fails++; $display("FAIL err_lhu_odd: got err/code/req %b want 1010", {err, err_code, mem_req}); end
        req_valid = 1'b0;
        step();
        checks++; if ({err, mem_req, req_ready} !== 3'b001) begin fails++; $display("FAIL err_clear: got err/req/rdy %b want 001", {err, mem_req, req_ready}); end
    endtask

    task automatic test_timeout();
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd7);
        step();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        step();
        step();
        checks++; if ({err, req_ready} !== 2'b00) begin fails++; $display("FAIL to_early: got err/rdy %b want 00", {err, req_ready}); end
        step();
        checks++; if ({err, err_code, req_ready, wb_valid} !== 5'b11110) begin fails++; $display("FAIL to_fire: got err/code/rdy/wb %b want 11110", {err, err_code, req_ready, wb_valid}); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        step();
        mem_rvalid = 1'b0;
        checks++; if ({wb_valid, done, err} !== 3'b000) begin fails++; $display("FAIL to_late_rvalid: got wb/done/err %b want 000", {wb_valid, done, err}); end
    endtask

    // Response after three idle WAIT cycles still completes, three cycles later than best case.
    task automatic test_slow_resp();
        issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd9);
        step();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        step();
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7FFF0000;
        step();
        mem_rvalid = 1'b0;
        checks++; if ({wb_valid, err, wb_data} !== {2'b10, 32'h00007FFF}) begin fails++; $display("FAIL slow_resp: got wb/err/data %b %b %h want 1 0 00007fff", wb_valid, err, wb_data); end
        step();
    endtask

    task automatic test_gnt_stall();
        issue(1'b0, 1'b1, 3'b010, 32'h40, 32'h11223344, 5'd0);
        step();
        req_valid = 1'b0;
        wdata     = 32'hFFFFFFFF;
        addr      = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== {2'b11, 32'h40, 4'b1111, 32'h11223344}) begin fails++; $display("FAIL stall_hold%0d: got %b %b %h %b %h", i, mem_req, mem_we, mem_addr, mem_be, mem_wdata); end
            step();
        end
        checks++; if (mem_req !== 1'b1) begin fails++; $display("FAIL stall_req: got %b want 1", mem_req); end
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        checks++; if ({done, wb_valid} !== 2'b10) begin fails++; $display("FAIL stall_done: got done/wb %b want 10", {done, wb_valid}); end
        step();
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd3);
        step();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst     = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, done, err, err_code, req_ready} !== {71'd0, 5'b00001}) begin fails++; $display("FAIL rstmid_out: got %b %b %h %b %h %b %b %b %b %b", mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, done, err, err_code, req_ready); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        step();
        mem_rvalid = 1'b0;
        checks++; if ({wb_valid, done, err} !== 3'b000) begin fails++; $display("FAIL rstmid_after: got wb/done/err %b want 000", {wb_valid, done, err}); end
    endtask

    initial begin
        test_reset();
        test_load("lw",  3'b010, 32'h100, 5'd5,  32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        test_load("lb",  3'b000, 32'h103, 5'd6,  32'h80FF1234, 4'b1000, 32'hFFFFFF80);
        test_load("lbu", 3'b100, 32'h103, 5'd6,  32'h80FF1234, 4'b1000, 32'h00000080);
        test_load("lh",  3'b001, 32'h102, 5'd10, 32'h80FF1234, 4'b1100, 32'hFFFF80FF);
        test_load("lhu", 3'b101, 32'h102, 5'd11, 32'h80FF1234, 4'b1100, 32'h000080FF);
        test_load("lb1", 3'b000, 32'h101, 5'd12, 32'h80FF1234, 4'b0010, 32'h00000012);
        test_store("sh", 3'b001, 32'h202, 32'h0000ABCD, 32'h200, 4'b1100, 32'hABCDABCD);
        test_store("sb", 3'b000, 32'h301, 32'h12345677, 32'h300, 4'b0010, 32'h77777777);
        test_errors();
        test_timeout();
        test_slow_resp();
        test_gnt_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
